frame_echo: RTL and testbench
=============================

Name: frame_echo

Overview:
- Far-end responder for the PRBS link test. It sits on the user side of xm_top at the remote board.
- Every frame received on the AXIS rx interface is stored, store-and-forward, in a circular buffer. Only complete, error-free frames are retransmitted unchanged on the AXIS tx interface.
- The near-end checker therefore sees its own pattern returned.
- Counters report echoed frames, dropped frames, and TX error responses.

Parameters:
- ADDR_WIDTH, 9, buffer depth = 2**ADDR_WIDTH words; each word holds data, vldb and last.
- P_WAIT_RSP, 1, when 1 the TX FSM waits for tx_rsp_valid_i after each frame before starting the next.

Ports:
- user_clk_i  in  1  single clock; rx and tx user clocks tied together at the top.
- user_rst_i  in  1  asynchronous, active-high reset.
- rx_data_i  in  32  received word.
- rx_vldb_i  in  2  valid bytes on the last beat, minus 1 (00 = 1 byte ... 11 = 4 bytes); don't-care on other beats.
- rx_valid_i  in  1  beat valid; no backpressure.
- rx_last_i  in  1  last beat of frame.
- rx_user_i  in  1  frame error flag, sampled on the last beat.
- tx_data_o  out  32  echoed word.
- tx_vldb_o  out  2  same encoding as rx_vldb_i.
- tx_valid_o  out  1  beat valid.
- tx_ready_i  in  1  MAC accepts the beat.
- tx_last_o  out  1  last beat.
- tx_user_o  out  1  constant 0.
- tx_status_i  in  1  per-frame TX status: 1 = error.
- tx_rsp_valid_i  in  1  tx_status_i valid strobe.
- echo_cnt_o  out  32  frames fully sent.
- drop_ovf_cnt_o  out  32  frames dropped because the buffer was full.
- drop_err_cnt_o  out  32  frames dropped because rx_user_i = 1.
- tx_err_cnt_o  out  32  responses with tx_status_i = 1.

Behaviour:
- Reset: all pointers and counters are 0. tx_valid_o, tx_last_o, tx_user_o = 0; tx_data_o and tx_vldb_o = 0. RX FSM goes to SYNC, TX FSM to IDLE.
- RX FSM states: SYNC, IDLE, WRITE, DISCARD.
  - SYNC: all beats are ignored until a beat with rx_last_i is seen, then go to IDLE. This prevents a partial frame after reset release from being echoed.
  - IDLE/WRITE: each valid beat is written at wr_ptr, then wr_ptr increments. The first beat records frm_start = wr_ptr.
  - Full condition: wr_ptr + 1 == rd_ptr (modulo depth).
  - Valid beat while full: beat is not written; go to DISCARD, or handle immediately if the beat is last.
  - Last beat with rx_user_i = 0 and no overflow: commit_ptr <= wr_ptr + 1.
  - Last beat with rx_user_i = 1: wr_ptr rewinds to frm_start; drop_err_cnt increments.
  - DISCARD: beats are ignored. On the last beat, wr_ptr rewinds to frm_start and drop_ovf_cnt increments. If rx_user_i is also 1 on that beat, only drop_ovf_cnt increments.
  - A single-beat frame (first and last beat in the same cycle) is legal and follows the same rules.
- Only commit_ptr is visible to the reader. An uncommitted frame is never read.
- TX FSM states: IDLE, SEND, WAIT_RSP.
  - IDLE -> SEND when rd_ptr != commit_ptr.
  - Buffer read latency is 1 cycle, with a one-entry output register.
  - Latency: rx last beat committed at cycle N, TX in IDLE -> tx_valid_o = 1 at cycle N+2.
  - SEND: AXIS rules apply. tx_data_o, tx_vldb_o and tx_last_o hold stable while tx_valid_o = 1 and tx_ready_i = 0.
  - In SEND, tx_valid_o does not drop between beats of a frame. The buffer always holds the whole committed frame, so back-to-back beats are produced with tx_ready_i held 1.
  - Beat accepted with tx_last_o = 1: echo_cnt increments. Go to WAIT_RSP if P_WAIT_RSP = 1, else IDLE.
  - WAIT_RSP: on tx_rsp_valid_i go to IDLE, and tx_err_cnt increments if tx_status_i = 1.
  - A tx_rsp_valid_i in any other state still updates tx_err_cnt.
- Concurrent RX write/commit and TX read in the same cycle are allowed.
- The full test uses the registered rd_ptr, so one slot is always kept empty.
- A frame longer than 2**ADDR_WIDTH - 1 words always ends in DISCARD.
- Counters wrap modulo 2**32.

Test Plan:
- Single 4-beat frame, last vldb = 10, tx_ready_i held 1 -> identical 4 beats out; tx_valid_o rises 2 cycles after the rx last beat; echo_cnt_o = 1 after tx_rsp_valid_i.
- Frame with rx_user_i = 1 on the last beat, then a good 2-beat frame -> only the 2-beat frame is echoed; drop_err_cnt_o = 1; echo_cnt_o = 1.
- ADDR_WIDTH = 4, tx_ready_i = 0, 20-beat frame -> frame is not echoed; drop_ovf_cnt_o = 1; wr_ptr returns to frm_start. A following 3-beat frame, after tx_ready_i = 1, is echoed intact.
- Reset released mid-frame (3 beats, then last) followed by a 2-beat frame -> the partial frame is ignored; only the 2-beat frame is echoed.
- Random tx_ready_i (50%) over 100 frames of 1-64 beats -> output stream equals input stream word for word. tx_data_o is stable while stalled; echo_cnt_o = 100.
- P_WAIT_RSP = 1, two frames committed, tx_rsp_valid_i delayed 10 cycles with tx_status_i = 1 -> the second frame starts only after the response; tx_err_cnt_o = 1.

Source files
------------

// File: rtl/frame_echo.sv
// Store-and-forward frame echo: complete, error-free AXIS rx frames are buffered in a circular
// RAM and replayed unchanged on AXIS tx, with drop/echo/tx-error statistics.
module frame_echo #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter bit          P_WAIT_RSP = 1'b1
) (
  input  logic        user_clk_i,
  input  logic        user_rst_i,
  input  logic [31:0] rx_data_i,
  input  logic [1:0]  rx_vldb_i,
  input  logic        rx_valid_i,
  input  logic        rx_last_i,
  input  logic        rx_user_i,
  output logic [31:0] tx_data_o,
  output logic [1:0]  tx_vldb_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        tx_last_o,
  output logic        tx_user_o,
  input  logic        tx_status_i,
  input  logic        tx_rsp_valid_i,
  output logic [31:0] echo_cnt_o,
  output logic [31:0] drop_ovf_cnt_o,
  output logic [31:0] drop_err_cnt_o,
  output logic [31:0] tx_err_cnt_o
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PtrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {RxSync, RxIdle, RxWrite, RxDiscard} rx_state_e;
  typedef enum logic [1:0] {TxIdle, TxSend, TxWaitRsp} tx_state_e;

  rx_state_e rx_state_q;
  tx_state_e tx_state_q;

  // Each entry: {last, vldb, data}
  logic [34:0] mem [Depth];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q, commit_ptr_q, frm_start_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_inc, rd_ptr_inc, cur_start;
  logic                  full, mem_we;

  logic [31:0] tx_data_q;
  logic [1:0]  tx_vldb_q;
  logic        tx_valid_q, tx_last_q;
  logic [31:0] echo_cnt_q, drop_ovf_cnt_q, drop_err_cnt_q, tx_err_cnt_q;

  assign wr_ptr_inc = wr_ptr_q + PtrOne;
  assign rd_ptr_inc = rd_ptr_q + PtrOne;
  // One slot stays empty so that wr_ptr == rd_ptr always means empty.
  assign full       = (wr_ptr_inc == rd_ptr_q);
  assign cur_start  = (rx_state_q == RxIdle) ? wr_ptr_q : frm_start_q;
  assign mem_we     = rx_valid_i && !full &&
                      ((rx_state_q == RxIdle) || (rx_state_q == RxWrite));

  always_ff @(posedge user_clk_i) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= {rx_last_i, rx_vldb_i, rx_data_i};
    end
  end

  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      rx_state_q     <= RxSync;
      wr_ptr_q       <= '0;
      commit_ptr_q   <= '0;
      frm_start_q    <= '0;
      drop_ovf_cnt_q <= '0;
      drop_err_cnt_q <= '0;
    end else if (rx_valid_i) begin
      case (rx_state_q)
        RxSync: begin
          if (rx_last_i) rx_state_q <= RxIdle;
        end
        RxIdle, RxWrite: begin
          frm_start_q <= cur_start;
          if (full) begin
            if (rx_last_i) begin
              wr_ptr_q       <= cur_start;
              drop_ovf_cnt_q <= drop_ovf_cnt_q + 32'd1;
              rx_state_q     <= RxIdle;
            end else begin
              rx_state_q <= RxDiscard;
            end
          end else if (rx_last_i) begin
            rx_state_q <= RxIdle;
            if (rx_user_i) begin
              wr_ptr_q       <= cur_start;
              drop_err_cnt_q <= drop_err_cnt_q + 32'd1;
            end else begin
              wr_ptr_q     <= wr_ptr_inc;
              commit_ptr_q <= wr_ptr_inc;
            end
          end else begin
            wr_ptr_q   <= wr_ptr_inc;
            rx_state_q <= RxWrite;
          end
        end
        RxDiscard: begin
          // An overflowed frame counts only as an overflow, even if it is also errored.
          if (rx_last_i) begin
            wr_ptr_q       <= frm_start_q;
            drop_ovf_cnt_q <= drop_ovf_cnt_q + 32'd1;
            rx_state_q     <= RxIdle;
          end
        end
        default: rx_state_q <= RxSync;
      endcase
    end
  end

  always_ff @(posedge user_clk_i or posedge user_rst_i) begin
    if (user_rst_i) begin
      tx_state_q   <= TxIdle;
      rd_ptr_q     <= '0;
      tx_data_q    <= '0;
      tx_vldb_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
      echo_cnt_q   <= '0;
      tx_err_cnt_q <= '0;
    end else begin
      if (tx_rsp_valid_i && tx_status_i) tx_err_cnt_q <= tx_err_cnt_q + 32'd1;
      case (tx_state_q)
        TxIdle: begin
          if (rd_ptr_q != commit_ptr_q) begin
            {tx_last_q, tx_vldb_q, tx_data_q} <= mem[rd_ptr_q];
            rd_ptr_q   <= rd_ptr_inc;
            tx_valid_q <= 1'b1;
            tx_state_q <= TxSend;
          end
        end
        TxSend: begin
          // The whole frame is committed, so the next beat is always available.
          if (tx_ready_i) begin
            if (tx_last_q) begin
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              echo_cnt_q <= echo_cnt_q + 32'd1;
              tx_state_q <= P_WAIT_RSP ? TxWaitRsp : TxIdle;
            end else begin
              {tx_last_q, tx_vldb_q, tx_data_q} <= mem[rd_ptr_q];
              rd_ptr_q <= rd_ptr_inc;
            end
          end
        end
        TxWaitRsp: begin
          if (tx_rsp_valid_i) tx_state_q <= TxIdle;
        end
        default: tx_state_q <= TxIdle;
      endcase
    end
  end

  assign tx_data_o      = tx_data_q;
  assign tx_vldb_o      = tx_vldb_q;
  assign tx_valid_o     = tx_valid_q;
  assign tx_last_o      = tx_last_q;
  assign tx_user_o      = 1'b0;
  assign echo_cnt_o     = echo_cnt_q;
  assign drop_ovf_cnt_o = drop_ovf_cnt_q;
  assign drop_err_cnt_o = drop_err_cnt_q;
  assign tx_err_cnt_o   = tx_err_cnt_q;

endmodule

// File: tb/tb_frame_echo.sv
// Bench for frame_echo: directed scenarios plus a randomized frame stream checked against a
// queue-based model of which frames must come back.
module tb_frame_echo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] rx_data;
  logic [1:0]  rx_vldb;
  logic        rx_valid, rx_last, rx_user;
  logic        tx_ready, tx_rsp_valid, tx_status;

  logic [31:0] m_data, m_echo, m_ovf, m_err, m_txerr;
  logic [1:0]  m_vldb;
  logic        m_valid, m_last, m_user;
  logic [31:0] s_data, s_echo, s_ovf, s_err, s_txerr;
  logic [1:0]  s_vldb;
  logic        s_valid, s_last, s_user;

  frame_echo #(.ADDR_WIDTH(9), .P_WAIT_RSP(1'b1)) dut (
    .user_clk_i(clk), .user_rst_i(rst),
    .rx_data_i(rx_data), .rx_vldb_i(rx_vldb), .rx_valid_i(rx_valid),
    .rx_last_i(rx_last), .rx_user_i(rx_user),
    .tx_data_o(m_data), .tx_vldb_o(m_vldb), .tx_valid_o(m_valid), .tx_ready_i(tx_ready),
    .tx_last_o(m_last), .tx_user_o(m_user), .tx_status_i(tx_status),
    .tx_rsp_valid_i(tx_rsp_valid),
    .echo_cnt_o(m_echo), .drop_ovf_cnt_o(m_ovf), .drop_err_cnt_o(m_err), .tx_err_cnt_o(m_txerr)
  );

  // Small buffer (15 usable words) for the overflow scenarios.
  frame_echo #(.ADDR_WIDTH(4), .P_WAIT_RSP(1'b0)) dut_s (
    .user_clk_i(clk), .user_rst_i(rst),
    .rx_data_i(rx_data), .rx_vldb_i(rx_vldb), .rx_valid_i(rx_valid),
    .rx_last_i(rx_last), .rx_user_i(rx_user),
    .tx_data_o(s_data), .tx_vldb_o(s_vldb), .tx_valid_o(s_valid), .tx_ready_i(tx_ready),
    .tx_last_o(s_last), .tx_user_o(s_user), .tx_status_i(tx_status),
    .tx_rsp_valid_i(tx_rsp_valid),
    .echo_cnt_o(s_echo), .drop_ovf_cnt_o(s_ovf), .drop_err_cnt_o(s_err), .tx_err_cnt_o(s_txerr)
  );

  int total = 0;
  int bad = 0;
  logic [34:0] exp_m[$];
  logic [34:0] exp_s[$];
  bit mon_m, mon_s, rand_ready, auto_rsp;
  bit m_stall, s_stall;
  logic [34:0] m_held, s_held;
  int lasts_seen, rsps_sent, m_extra, s_extra;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample outputs at the negedge, then advance past the next posedge and drive inputs.
  task automatic step();
    logic [34:0] e;
    @(negedge clk);
    if (mon_m) begin
      if (m_stall) begin
        check("m_valid_hold", m_valid, 1'b1);
        check("m_beat_hold", {m_last, m_vldb, m_data}, m_held);
      end
      if (m_valid && tx_ready) begin
        check("m_user", m_user, 1'b0);
        if (exp_m.size() == 0) m_extra++;
        else begin
          e = exp_m.pop_front();
          check("m_data", m_data, e[31:0]);
          check("m_last", m_last, e[34]);
          if (e[34]) check("m_vldb", m_vldb, e[33:32]);
        end
        if (m_last) lasts_seen++;
      end
      m_stall = m_valid && !tx_ready;
      m_held  = {m_last, m_vldb, m_data};
    end
    if (mon_s) begin
      if (s_stall) begin
        check("s_valid_hold", s_valid, 1'b1);
        check("s_beat_hold", {s_last, s_vldb, s_data}, s_held);
      end
      if (s_valid && tx_ready) begin
        if (exp_s.size() == 0) s_extra++;
        else begin
          e = exp_s.pop_front();
          check("s_data", s_data, e[31:0]);
          check("s_last", s_last, e[34]);
          if (e[34]) check("s_vldb", s_vldb, e[33:32]);
        end
      end
      s_stall = s_valid && !tx_ready;
      s_held  = {s_last, s_vldb, s_data};
    end
    @(posedge clk);
    #1;
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
    if (auto_rsp) begin
      if (lasts_seen > rsps_sent) begin
        tx_rsp_valid = 1'b1;
        tx_status    = 1'b0;
        rsps_sent++;
      end else begin
        tx_rsp_valid = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0; rx_last = 1'b0; rx_user = 1'b0; rx_data = '0; rx_vldb = '0;
    tx_rsp_valid = 1'b0; tx_status = 1'b0;
    exp_m.delete(); exp_s.delete();
    m_stall = 1'b0; s_stall = 1'b0;
    lasts_seen = 0; rsps_sent = 0; m_extra = 0; s_extra = 0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  // A lone last beat moves the receiver out of its post-reset sync state.
  task automatic sync_rx();
    rx_valid = 1'b1; rx_last = 1'b1; rx_user = 1'b0;
    step();
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  // Model: an error-free frame is echoed; the small buffer can only hold 15 words at once.
  task automatic send_frame(input int len, input logic user, input logic [1:0] lv,
                            input bit gaps);
    logic [34:0] words[$];
    logic [34:0] w;
    for (int i = 0; i < len; i++) begin
      w = {1'(i == len - 1), (i == len - 1) ? lv : 2'($urandom_range(0, 3)), 32'($urandom)};
      words.push_back(w);
    end
    if (!user) begin
      foreach (words[i]) exp_m.push_back(words[i]);
      if (len <= 15) foreach (words[i]) exp_s.push_back(words[i]);
    end
    for (int i = 0; i < len; i++) begin
      while (gaps && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
        step();
      end
      rx_valid = 1'b1;
      {rx_last, rx_vldb, rx_data} = words[i];
      rx_user = user;
      step();
    end
    rx_valid = 1'b0; rx_last = 1'b0; rx_user = 1'b0;
  endtask

  task automatic drain_m(input int budget);
    int n = 0;
    while (exp_m.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("m_drain_left", exp_m.size(), 0);
    repeat (4) step();
    check("m_extra_beats", m_extra, 0);
  endtask

  task automatic drain_s(input int budget);
    int n = 0;
    while (exp_s.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("s_drain_left", exp_s.size(), 0);
    repeat (4) step();
    check("s_extra_beats", s_extra, 0);
  endtask

  initial begin
    bit any_valid;
    int n;
    int len;
    rst = 1'b1; tx_ready = 1'b1; rand_ready = 1'b0; auto_rsp = 1'b1;
    mon_m = 1'b1; mon_s = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", m_valid, 1'b0);
    check("rst_last", m_last, 1'b0);
    check("rst_user", m_user, 1'b0);
    check("rst_data", m_data, 32'h0);
    check("rst_vldb", m_vldb, 2'b00);
    check("rst_echo", m_echo, 32'h0);
    check("rst_ovf", m_ovf, 32'h0);
    check("rst_err", m_err, 32'h0);
    check("rst_txerr", m_txerr, 32'h0);

    // Single 4-beat frame: tx_valid rises two cycles after the last rx beat
    do_reset();
    sync_rx();
    send_frame(4, 1'b0, 2'b10, 1'b0);
    check("t1_lat_n1", m_valid, 1'b0);
    step();
    check("t1_lat_n2", m_valid, 1'b1);
    drain_m(50);
    check("t1_echo", m_echo, 32'd1);
    check("t1_rsp_seen", rsps_sent, 1);

    // Errored frame dropped, following good frame echoed
    do_reset();
    sync_rx();
    send_frame(3, 1'b1, 2'b01, 1'b0);
    send_frame(2, 1'b0, 2'b11, 1'b0);
    drain_m(50);
    check("t2_drop_err", m_err, 32'd1);
    check("t2_echo", m_echo, 32'd1);
    check("t2_ovf", m_ovf, 32'd0);

    // Overflow on the 16-entry buffer, then frames that fit are echoed intact
    do_reset();
    mon_m = 1'b0; mon_s = 1'b1;
    sync_rx();
    tx_ready = 1'b0;
    send_frame(20, 1'b0, 2'b00, 1'b0);
    repeat (3) step();
    check("t3_ovf", s_ovf, 32'd1);
    check("t3_no_tx", s_valid, 1'b0);
    check("t3_echo0", s_echo, 32'd0);
    tx_ready = 1'b1;
    send_frame(3, 1'b0, 2'b01, 1'b0);
    drain_s(50);
    check("t3_echo1", s_echo, 32'd1);
    tx_ready = 1'b0;
    send_frame(15, 1'b0, 2'b11, 1'b0);
    repeat (5) step();
    tx_ready = 1'b1;
    drain_s(80);
    check("t3_echo2", s_echo, 32'd2);
    check("t3_ovf_final", s_ovf, 32'd1);
    mon_s = 1'b0; mon_m = 1'b1;

    // Reset released in the middle of a frame
    do_reset();
    rst = 1'b1;
    rx_valid = 1'b1; rx_last = 1'b0; rx_data = 32'hdead_beef;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_data = 32'($urandom);
      step();
    end
    rx_last = 1'b1;
    step();
    rx_valid = 1'b0; rx_last = 1'b0;
    send_frame(2, 1'b0, 2'b10, 1'b0);
    drain_m(50);
    check("t4_echo", m_echo, 32'd1);
    check("t4_err", m_err, 32'd0);
    check("t4_ovf", m_ovf, 32'd0);

    // Random stream, 100 frames, random tx_ready
    do_reset();
    sync_rx();
    rand_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      len = $urandom_range(1, 64);
      n = 0;
      while (exp_m.size() + len > 400 && n < 5000) begin
        step();
        n++;
      end
      send_frame(len, 1'b0, 2'($urandom_range(0, 3)), 1'b1);
    end
    drain_m(20000);
    rand_ready = 1'b0; tx_ready = 1'b1;
    check("t5_echo", m_echo, 32'd100);
    check("t5_ovf", m_ovf, 32'd0);
    check("t5_err", m_err, 32'd0);

    // Second frame waits for the delayed, errored response
    do_reset();
    sync_rx();
    auto_rsp = 1'b0;
    send_frame(2, 1'b0, 2'b01, 1'b0);
    send_frame(3, 1'b0, 2'b10, 1'b0);
    n = 0;
    while (lasts_seen < 1 && n < 50) begin
      step();
      n++;
    end
    check("t6_first_done", lasts_seen, 1);
    any_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      any_valid |= m_valid;
    end
    check("t6_held_off", any_valid, 1'b0);
    check("t6_pending", exp_m.size(), 3);
    tx_rsp_valid = 1'b1; tx_status = 1'b1;
    step();
    tx_rsp_valid = 1'b0; tx_status = 1'b0;
    check("t6_txerr1", m_txerr, 32'd1);
    step();
    check("t6_second_start", m_valid, 1'b1);
    drain_m(50);
    check("t6_echo", m_echo, 32'd2);
    tx_rsp_valid = 1'b1; tx_status = 1'b0;
    step();
    tx_rsp_valid = 1'b0;
    check("t6_txerr_ok_rsp", m_txerr, 32'd1);
    step();
    tx_rsp_valid = 1'b1; tx_status = 1'b1;
    step();
    tx_rsp_valid = 1'b0; tx_status = 1'b0;
    check("t6_txerr_idle_rsp", m_txerr, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
